quad_decoder_counter: RTL and testbench
=======================================

Name: quad_decoder_counter

Overview:
Receive end of a quadrature (A/B) position interface, the counterpart of the up/down counter, which consumes a direction/step pair. It samples asynchronous A/B lines, synchronizes and glitch-filters them, and decodes the Gray-code transitions into up/down steps. It keeps an N-bit wrapping position count and flags illegal transitions. The block sits between the external encoder pins and position/speed logic.

Parameters:
N, 8, position counter width in bits.
FILT, 3, consecutive clocks a new synchronized level must persist before it is accepted (minimum 1).

Ports:
clk  input  1  single system clock, rising edge.
reset  input  1  asynchronous, active-low reset.
a_in  input  1  quadrature channel A, asynchronous to clk.
b_in  input  1  quadrature channel B, asynchronous to clk.
clr  input  1  synchronous clear of position count, active-high.
q  output  N  position count, wraps modulo 2^N.
dir  output  1  direction of last valid step: 0 = up, 1 = down (same convention as the counter's mode input).
step  output  1  one-clock pulse per valid decoded step.
err  output  1  one-clock pulse on an illegal transition (both channels changed).

Behaviour:
- Reset (reset=0, asynchronous): q=0, dir=0, step=0, err=0. Synchronizer flops, filtered levels and the previous-state register go to 0. Filter counters go to 0. Everything holds until reset=1.
- Synchronizer: 2 flops per channel. No logic on the first flop.
- Filter, per channel:
  - The counter increments each clock while the synchronized level differs from the filtered level.
  - When the counter reaches FILT-1 and the levels still differ, filtered <= synchronized and the counter is set to 0.
  - Any clock where the levels match sets the counter to 0, so pulses shorter than FILT clocks are rejected.
- Decode: each clock, prev <= {A_f,B_f}. Compare the current {A_f,B_f} with prev.
  - Up sequence (A leads): 00->10->11->01->00. The matching transition gives step=1, dir=0, q<=q+1.
  - Down sequence: 00->01->11->10->00. The matching transition gives step=1, dir=1, q<=q-1.
  - No change: step=0, err=0; q and dir hold.
  - Both bits changed (00<->11, 10<->01): err=1, step=0; q and dir hold. prev still updates, so the next legal transition counts from the new state.
- x4 decoding: one count per edge of either channel, so one full encoder cycle = 4 counts.
- Wrap: q=2^N-1 up -> 0; q=0 down -> 2^N-1. No saturation and no overflow flag.
- clr=1: q<=0 on that edge. clr wins over a simultaneous step. step and dir still report the decoded transition that cycle. err is unaffected by clr.
- Latency: call the rising edge that first samples a new a_in/b_in level edge 1. q, step and dir update on edge FILT+3 (edge 6 for FILT=3).
- Reset asserted mid-operation: all state clears immediately. After release, the first decode compares against prev=00. If the inputs are already non-zero, the filter must accept them first, which may produce one step or err. This is the defined behaviour and the bench must tolerate it.
- Width rules: q arithmetic is N bits unsigned, with the carry discarded. Filter counter width is clog2(FILT+1).

Decomposition:
- Shared package qdec_pkg:
  - state encodings S00/S10/S11/S01;
  - a function next_up(state) returning the successor in the up sequence, whose inverse defines down;
  - a clog2-based filter counter width helper.
- One sub-module qdec_filter (parameter FILT; ports clk, reset, din, dout) containing the 2-flop synchronizer and the glitch filter. It is instantiated once for A and once for B.
- The top level holds the decode, the counter and the output registers.

Test Plan:
1. Clock period 40 ns. Hold reset=0 for 50 ns, with a_in=b_in=0 -> q=0, dir=0, step=0, err=0 throughout. Release, idle 10 clocks -> no step pulses.
2. Drive the up sequence 00->10->11->01->00 twice, each state held 10 clocks -> 8 step pulses, dir=0, q=8. The first q change lands exactly on edge 6 after a_in rises (FILT=3).
3. From q=0, one down transition 00->01 -> q=8'hFF, dir=1, step pulses once. Then 01->00 (up) -> q=0, dir=0.
4. With the filtered state 00, pulse a_in high for 2 clocks, then low -> no step, no err, q unchanged. Repeat with a 3-clock pulse -> filter accepts it, giving step with q+1, then q-1 when it returns to 0.
5. From filtered 00, toggle a_in and b_in in the same cycle to 11 -> err pulses for exactly 1 clock, step=0, q unchanged. Next 11->01 -> q+1, dir=0.
6. At q=5, assert clr on the same edge a valid up step decodes -> q=0, step=1. Then at q=3, drop reset asynchronously mid-clock -> q=0 immediately, before the next clk edge.

Source files
------------

// File: rtl/qdec_pkg.sv
// Shared definitions for the quadrature decoder.
// Provides:
//   qstate_t         - {A,B} channel state encodings S00/S10/S11/S01
//   next_up()        - successor of a state in the up (A leads) sequence;
//                      the down sequence is its inverse
//   filt_cnt_width() - width of a glitch-filter counter that counts up to FILT
package qdec_pkg;

  typedef enum logic [1:0] {
    S00 = 2'b00,
    S01 = 2'b01,
    S10 = 2'b10,
    S11 = 2'b11
  } qstate_t;

  // Up sequence: 00 -> 10 -> 11 -> 01 -> 00.
  function automatic qstate_t next_up(input qstate_t s);
    qstate_t n;
    unique case (s)
      S00:     n = S10;
      S10:     n = S11;
      S11:     n = S01;
      default: n = S00;
    endcase
    return n;
  endfunction

  function automatic int unsigned filt_cnt_width(input int unsigned filt);
    return (filt + 1 <= 2) ? 1 : $clog2(filt + 1);
  endfunction

endpackage

// File: rtl/qdec_filter.sv
// Two-flop synchronizer followed by a persistence glitch filter for one
// quadrature channel. A new synchronized level is accepted only after it has
// differed from the filtered level for FILT consecutive clocks.
// Ports:
//   clk   - system clock, rising edge
//   reset - asynchronous active-low reset
//   din   - raw channel input, asynchronous to clk
//   dout  - synchronized, filtered level
module qdec_filter
  import qdec_pkg::*;
#(
  parameter int unsigned FILT = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);

  localparam int unsigned CW = filt_cnt_width(FILT);
  localparam logic [CW-1:0] CntLast = CW'(FILT - 1);

  logic          sync1_q, sync2_q;
  logic          filt_q, filt_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Plain flop chain; nothing between the two stages.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= din;
      sync2_q <= sync1_q;
    end
  end

  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (sync2_q != filt_q) begin
      if (cnt_q == CntLast) begin
        filt_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      filt_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end

  assign dout = filt_q;

endmodule

// File: rtl/quad_decoder_counter.sv
// Quadrature (A/B) receiver: synchronizes and filters both channels, decodes
// Gray-code transitions x4 into up/down steps and keeps a wrapping position.
// Ports:
//   clk   - system clock, rising edge
//   reset - asynchronous active-low reset
//   a_in  - channel A, asynchronous
//   b_in  - channel B, asynchronous
//   clr   - synchronous clear of the position count (wins over a step)
//   q     - N-bit position count, wraps modulo 2^N
//   dir   - direction of last valid step: 0 = up, 1 = down
//   step  - one-clock pulse per valid step
//   err   - one-clock pulse when both channels changed together
module quad_decoder_counter
  import qdec_pkg::*;
#(
  parameter int unsigned N    = 8,
  parameter int unsigned FILT = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         a_in,
  input  logic         b_in,
  input  logic         clr,
  output logic [N-1:0] q,
  output logic         dir,
  output logic         step,
  output logic         err
);

  logic    a_f, b_f;
  qstate_t cur, prev_q;
  logic    is_up, is_dn, changed;

  logic [N-1:0] q_q, q_d;
  logic         dir_q, dir_d;
  logic         step_q, step_d;
  logic         err_q, err_d;

  qdec_filter #(
    .FILT(FILT)
  ) u_filt_a (
    .clk  (clk),
    .reset(reset),
    .din  (a_in),
    .dout (a_f)
  );

  qdec_filter #(
    .FILT(FILT)
  ) u_filt_b (
    .clk  (clk),
    .reset(reset),
    .din  (b_in),
    .dout (b_f)
  );

  assign cur     = qstate_t'({a_f, b_f});
  assign changed = (cur != prev_q);
  // next_up never maps a state to itself, so these are false when unchanged.
  assign is_up   = (cur == next_up(prev_q));
  assign is_dn   = (prev_q == next_up(cur));

  always_comb begin
    q_d    = q_q;
    dir_d  = dir_q;
    step_d = 1'b0;
    err_d  = 1'b0;
    if (is_up) begin
      q_d    = q_q + N'(1);
      dir_d  = 1'b0;
      step_d = 1'b1;
    end else if (is_dn) begin
      q_d    = q_q - N'(1);
      dir_d  = 1'b1;
      step_d = 1'b1;
    end else if (changed) begin
      err_d = 1'b1;
    end
    if (clr) begin
      q_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_q <= S00;
      q_q    <= '0;
      dir_q  <= 1'b0;
      step_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      // prev follows the filtered state even on an illegal jump.
      prev_q <= cur;
      q_q    <= q_d;
      dir_q  <= dir_d;
      step_q <= step_d;
      err_q  <= err_d;
    end
  end

  assign q    = q_q;
  assign dir  = dir_q;
  assign step = step_q;
  assign err  = err_q;

endmodule

// File: tb/tb_quad_decoder_counter.sv
module tb_quad_decoder_counter;

  localparam int unsigned N    = 8;
  localparam int unsigned FILT = 3;

  logic         clk   = 1'b0;
  logic         reset = 1'b0;
  logic         a_in  = 1'b0;
  logic         b_in  = 1'b0;
  logic         clr   = 1'b0;
  logic [N-1:0] q;
  logic         dir, step, err;

  int checks   = 0;
  int errors   = 0;
  int step_cnt = 0;
  int err_cnt  = 0;

  quad_decoder_counter #(
    .N   (N),
    .FILT(FILT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .a_in (a_in),
    .b_in (b_in),
    .clr  (clr),
    .q    (q),
    .dir  (dir),
    .step (step),
    .err  (err)
  );

  always #20 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Position of a {A,B} pattern along the up cycle 00,10,11,01.
  function automatic int pos(input logic [1:0] s);
    case (s)
      2'b00:   return 0;
      2'b10:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  // ---------------- behavioural reference model ----------------
  // Each channel: raw input reaches the filter two clocks late; a differing
  // level must be seen FILT clocks in a row before it is adopted. Decode
  // looks at the cycle distance between successive filtered states.
  logic         m_s1 [2];
  logic         m_s2 [2];
  logic         m_f  [2];
  int           m_run[2];
  logic [1:0]   m_prev = 2'b00;
  logic [N-1:0] m_q    = '0;
  logic         m_dir  = 1'b0;
  logic         m_step = 1'b0;
  logic         m_err  = 1'b0;

  initial begin
    for (int c = 0; c < 2; c++) begin
      m_s1[c] = 0; m_s2[c] = 0; m_f[c] = 0; m_run[c] = 0;
    end
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        for (int c = 0; c < 2; c++) begin
          m_s1[c] = 0; m_s2[c] = 0; m_f[c] = 0; m_run[c] = 0;
        end
        m_prev = 2'b00; m_q = '0; m_dir = 0; m_step = 0; m_err = 0;
      end else begin
        logic [1:0] cur;
        logic       inp[2];
        int         d;
        cur = {m_f[0], m_f[1]};
        d = (pos(cur) - pos(m_prev) + 4) % 4;
        m_step = (d == 1) || (d == 3);
        m_err  = (d == 2);
        if (d == 1) m_dir = 1'b0;
        if (d == 3) m_dir = 1'b1;
        if (clr) m_q = '0;
        else if (d == 1) m_q = m_q + 1'b1;
        else if (d == 3) m_q = m_q - 1'b1;
        m_prev = cur;
        inp[0] = a_in;
        inp[1] = b_in;
        for (int c = 0; c < 2; c++) begin
          if (m_s2[c] != m_f[c]) begin
            m_run[c]++;
            if (m_run[c] == int'(FILT)) begin
              m_f[c]   = m_s2[c];
              m_run[c] = 0;
            end
          end else begin
            m_run[c] = 0;
          end
          m_s2[c] = m_s1[c];
          m_s1[c] = inp[c];
        end
      end
    end
  end

  // Per-cycle compare, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      check("cmp_q", 32'(q), 32'(m_q));
      check("cmp_dir", 32'(dir), 32'(m_dir));
      check("cmp_step", 32'(step), 32'(m_step));
      check("cmp_err", 32'(err), 32'(m_err));
      step_cnt += int'(step);
      err_cnt  += int'(err);
    end
  end

  // ---------------- stimulus ----------------
  task automatic set_ab(input logic a, input logic b, input int hold);
    @(negedge clk);
    a_in = a;
    b_in = b;
    repeat (hold) @(posedge clk);
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  logic [1:0] pat[4];
  int s0, e0;

  initial begin
    pat[0] = 2'b00; pat[1] = 2'b10; pat[2] = 2'b11; pat[3] = 2'b01;

    // 1. reset
    #50;
    check("rst_q", 32'(q), 32'h0);
    check("rst_dir", 32'(dir), 32'h0);
    check("rst_step", 32'(step), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    repeat (10) @(posedge clk);
    #1 check("idle_steps", 32'(step_cnt), 32'h0);

    // 2. up sequence twice, with latency pinned on the first edge
    s0 = step_cnt;
    @(negedge clk);
    a_in = 1'b1;
    repeat (5) @(posedge clk);
    #1 check("lat_e5_q", 32'(q), 32'h0);
    check("lat_e5_step", 32'(step), 32'h0);
    @(posedge clk);
    #1 check("lat_e6_q", 32'(q), 32'h1);
    check("lat_e6_step", 32'(step), 32'h1);
    repeat (4) @(posedge clk);
    set_ab(1, 1, 10);
    set_ab(0, 1, 10);
    set_ab(0, 0, 10);
    for (int k = 0; k < 4; k++) set_ab(pat[(k + 1) % 4][1], pat[(k + 1) % 4][0], 10);
    #1 check("up2_q", 32'(q), 32'h8);
    check("up2_dir", 32'(dir), 32'h0);
    check("up2_steps", 32'(step_cnt - s0), 32'h8);

    // 3. down wrap, then back up
    pulse_clr();
    #1 check("clr_q", 32'(q), 32'h0);
    s0 = step_cnt;
    set_ab(0, 1, 10);
    #1 check("wrap_q", 32'(q), 32'hFF);
    check("wrap_dir", 32'(dir), 32'h1);
    check("wrap_steps", 32'(step_cnt - s0), 32'h1);
    set_ab(0, 0, 10);
    #1 check("unwrap_q", 32'(q), 32'h0);
    check("unwrap_dir", 32'(dir), 32'h0);

    // 4. glitch rejection and minimum accepted pulse
    s0 = step_cnt; e0 = err_cnt;
    @(negedge clk); a_in = 1'b1;
    repeat (2) @(negedge clk); a_in = 1'b0;
    repeat (10) @(posedge clk);
    #1 check("glitch2_q", 32'(q), 32'h0);
    check("glitch2_steps", 32'(step_cnt - s0), 32'h0);
    check("glitch2_errs", 32'(err_cnt - e0), 32'h0);
    @(negedge clk); a_in = 1'b1;
    repeat (3) @(negedge clk); a_in = 1'b0;
    repeat (12) @(posedge clk);
    #1 check("pulse3_q", 32'(q), 32'h0);
    check("pulse3_steps", 32'(step_cnt - s0), 32'h2);

    // 5. illegal jump
    s0 = step_cnt; e0 = err_cnt;
    set_ab(1, 1, 10);
    #1 check("illegal_errs", 32'(err_cnt - e0), 32'h1);
    check("illegal_steps", 32'(step_cnt - s0), 32'h0);
    check("illegal_q", 32'(q), 32'h0);
    set_ab(0, 1, 10);
    #1 check("after_illegal_q", 32'(q), 32'h1);
    check("after_illegal_dir", 32'(dir), 32'h0);

    // 6. clr against a simultaneous step, then async reset mid-clock
    pulse_clr();
    set_ab(0, 0, 10);
    set_ab(1, 0, 10);
    set_ab(1, 1, 10);
    set_ab(0, 1, 10);
    set_ab(0, 0, 10);
    #1 check("q_five", 32'(q), 32'h5);
    @(negedge clk); a_in = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk); clr = 1'b1;
    @(posedge clk);
    #1 check("clr_step_q", 32'(q), 32'h0);
    check("clr_step_step", 32'(step), 32'h1);
    check("clr_step_dir", 32'(dir), 32'h0);
    @(negedge clk); clr = 1'b0;
    set_ab(1, 1, 10);
    set_ab(0, 1, 10);
    set_ab(0, 0, 10);
    #1 check("q_three", 32'(q), 32'h3);
    @(posedge clk);
    #5 reset = 1'b0;
    #1 check("async_rst_q", 32'(q), 32'h0);
    check("async_rst_step", 32'(step), 32'h0);
    check("async_rst_err", 32'(err), 32'h0);
    a_in = 1'b1; b_in = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (10) @(posedge clk);

    // Random phase: legal steps, illegal jumps, short glitches, clears.
    for (int i = 0; i < 400; i++) begin
      int r, hold, p;
      r    = $urandom_range(0, 99);
      hold = $urandom_range(1, 8);
      p    = pos({a_in, b_in});
      if (r < 60) begin
        p = ($urandom_range(0, 1) == 1) ? (p + 1) % 4 : (p + 3) % 4;
        set_ab(pat[p][1], pat[p][0], hold);
      end else if (r < 70) begin
        set_ab(~a_in, ~b_in, hold);
      end else if (r < 90) begin
        int len;
        logic ch;
        len = $urandom_range(1, FILT + 1);
        ch  = 1'($urandom_range(0, 1));
        @(negedge clk);
        if (ch) a_in = ~a_in; else b_in = ~b_in;
        repeat (len) @(negedge clk);
        if (ch) a_in = ~a_in; else b_in = ~b_in;
        repeat (hold) @(posedge clk);
      end else begin
        pulse_clr();
      end
    end
    repeat (20) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
